// File: rtl/handshake_sequencer_if.sv
// handshake_sequencer_if: request, worker handshake and status bundle for handshake_sequencer
interface handshake_sequencer_if #(
  parameter int NUM_CH = 4
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] x;
  logic [NUM_CH-1:0] err_clr;
  logic [NUM_CH-1:0] q;
  logic [NUM_CH-1:0] err;
  logic rdy;
  logic start;
  logic busy;
  logic done;
  logic fail;
  logic [CW-1:0] ch_id;
  modport master (output x, rdy, err_clr, input start, ch_id, q, busy, done, fail, err);
  modport slave (input x, rdy, err_clr, output start, ch_id, q, busy, done, fail, err);
endinterface

// File: rtl/handshake_sequencer.sv
// handshake_sequencer: round-robin multi-channel start/rdy sequencer with timeout, retry and sticky errors
module handshake_sequencer #(
  parameter int NUM_CH = 4,
  parameter int TIMEOUT = 16,
  parameter int MAX_RETRY = 2
) (
  input logic clk,
  input logic reset,
  handshake_sequencer_if.slave bus
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, FAIL} state_t;
  state_t state;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] sel;
  logic [CW-1:0] nxt;
  logic [NUM_CH-1:0] elig;
  logic [2*NUM_CH-1:0] rot;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic target;
  assign elig = (bus.x ^ bus.q) & ~bus.err;
  assign rot = {elig, elig} >> rr_ptr;
  assign nxt = bus.ch_id == CW'(NUM_CH - 1) ? '0 : bus.ch_id + 1'b1;
  // first eligible channel at or after rr_ptr, wrapping; lowest offset wins
  always_comb begin
    sel = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (rot[k]) sel = CW'((int'(rr_ptr) + k) % NUM_CH);
  end
  // transaction FSM; ch_id doubles as the latched current channel, outputs registered with state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      timer <= '0;
      retry <= '0;
      target <= 1'b0;
      bus.ch_id <= '0;
      bus.q <= '0;
      bus.err <= '0;
      bus.start <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.fail <= 1'b0;
    end else begin
      bus.err <= bus.err & ~bus.err_clr;
      bus.start <= 1'b0;
      bus.done <= 1'b0;
      bus.fail <= 1'b0;
      case (state)
        IDLE:
          if (|elig) begin
            state <= ISSUE;
            bus.ch_id <= sel;
            target <= bus.x[sel];
            retry <= '0;
            bus.start <= 1'b1;
            bus.busy <= 1'b1;
          end
        ISSUE: begin
          state <= WAIT;
          timer <= '0;
        end
        WAIT:
          if (bus.rdy) begin
            state <= DONE;
            bus.q[bus.ch_id] <= target;
            bus.done <= 1'b1;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            if (retry < RW'(MAX_RETRY)) begin
              state <= ISSUE;
              retry <= retry + 1'b1;
              bus.start <= 1'b1;
            end else begin
              state <= FAIL;
              bus.err[bus.ch_id] <= 1'b1;
              bus.fail <= 1'b1;
            end
          end else timer <= timer + 1'b1;
        DONE, FAIL: begin
          state <= IDLE;
          rr_ptr <= nxt;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_handshake_sequencer.sv
// tb_handshake_sequencer: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_handshake_sequencer;
  typedef struct {
    int kind;
    int ch;
    logic [3:0] v;
    int dt;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mism = 0;
  int cyc = 0;
  int last = 0;
  ev_t sbq[$];
  handshake_sequencer_if #(.NUM_CH(4)) bus();
  handshake_sequencer #(.NUM_CH(4), .TIMEOUT(4), .MAX_RETRY(1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // monitor: every start/done/fail pulse must match the next expected event
  always @(negedge clk)
    if (!reset && (bus.start || bus.done || bus.fail)) begin
      int k;
      logic [3:0] v;
      ev_t e;
      k = bus.start ? 0 : bus.done ? 1 : 2;
      v = k == 1 ? bus.q : k == 2 ? bus.err : 4'b0;
      compared++;
      if (sbq.size() == 0) begin
        mism++;
        $display("FAIL unexpected_event: got kind=%0d ch=%0d val=%b, required no event", k, bus.ch_id, v);
      end else begin
        e = sbq.pop_front();
        if (e.kind != k || e.ch != int'(bus.ch_id) || (e.dt >= 0 && e.dt != cyc - last) || (k != 0 && e.v != v)) begin
          mism++;
          $display("FAIL sb_event: got kind=%0d ch=%0d val=%b dt=%0d, required kind=%0d ch=%0d val=%b dt=%0d",
                   k, bus.ch_id, v, cyc - last, e.kind, e.ch, e.v, e.dt);
        end
      end
      last = cyc;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic push(input int kind, input int ch, input logic [3:0] v, input int dt);
    ev_t e;
    e.kind = kind;
    e.ch = ch;
    e.v = v;
    e.dt = dt;
    sbq.push_back(e);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ev(input int kind, output int n);
    logic hit;
    n = 0;
    do begin
      tick(1);
      n++;
      hit = kind == 0 ? bus.start : bus.fail;
    end while (!hit && n < 40);
    if (!hit) begin
      compared++;
      mism++;
      $display("FAIL wait_kind%0d: got no pulse in %0d cycles, required one", kind, n);
    end
  endtask
  task automatic pulse_rdy(input int n);
    tick(n);
    bus.rdy = 1'b1;
    tick(1);
    bus.rdy = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_pulses"}, {29'b0, bus.start, bus.done, bus.fail}, 0);
    chk({tag, "_q"}, 32'(bus.q), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_ch_id"}, 32'(bus.ch_id), 0);
  endtask
  initial begin
    int n;
    bus.x = '0;
    bus.rdy = 1'b0;
    bus.err_clr = '0;
    tick(2);
    chk_reset("rst0");
    // 1: single channel, rdy two cycles after start
    bus.x = 4'b0001;
    push(0, 0, 4'b0, -1);
    push(1, 0, 4'b0001, 3);
    reset = 1'b0;
    wait_ev(0, n);
    pulse_rdy(2);
    tick(6);
    chk("t1_q", 32'(bus.q), 32'h1);
    chk("t1_busy", 32'(bus.busy), 0);
    // 2: two channels served in round-robin order from a fresh pointer
    bus.x = 4'b1010;
    do_reset();
    push(0, 1, 4'b0, -1);
    push(1, 1, 4'b0010, 2);
    push(0, 3, 4'b0, 2);
    push(1, 3, 4'b1010, 2);
    for (int i = 0; i < 2; i++) begin
      wait_ev(0, n);
      pulse_rdy(1);
    end
    tick(5);
    chk("t2_q", 32'(bus.q), 32'hA);
    chk("t2_busy", 32'(bus.busy), 0);
    // 3: no rdy -> one retry then fail, sticky error, then clear re-enables
    bus.x = 4'b1110;
    push(0, 2, 4'b0, -1);
    push(0, 2, 4'b0, 5);
    push(2, 2, 4'b0100, 5);
    wait_ev(2, n);
    tick(4);
    chk("t3_err", 32'(bus.err), 32'h4);
    chk("t3_q", 32'(bus.q), 32'hA);
    chk("t3_busy", 32'(bus.busy), 0);
    push(0, 2, 4'b0, -1);
    push(1, 2, 4'b1110, 2);
    bus.err_clr = 4'b0100;
    tick(1);
    bus.err_clr = '0;
    chk("t3_err_clr", 32'(bus.err), 0);
    wait_ev(0, n);
    chk("t3_clr_to_start", 32'(n + 1), 2);
    pulse_rdy(1);
    tick(4);
    chk("t3_q2", 32'(bus.q), 32'hE);
    // 4: rdy on the timeout cycle wins over retry
    bus.x = 4'b1111;
    push(0, 0, 4'b0, -1);
    push(1, 0, 4'b1111, 5);
    wait_ev(0, n);
    pulse_rdy(4);
    tick(8);
    chk("t4_q", 32'(bus.q), 32'hF);
    chk("t4_err", 32'(bus.err), 0);
    // 5: x toggles back during WAIT; latched target commits, then a second transaction
    bus.x = 4'b0001;
    do_reset();
    push(0, 0, 4'b0, -1);
    push(1, 0, 4'b0001, 2);
    push(0, 0, 4'b0, 2);
    push(1, 0, 4'b0000, 2);
    wait_ev(0, n);
    tick(1);
    bus.x = 4'b0000;
    bus.rdy = 1'b1;
    tick(1);
    bus.rdy = 1'b0;
    chk("t5_q_mid", 32'(bus.q), 32'h1);
    wait_ev(0, n);
    pulse_rdy(1);
    tick(4);
    chk("t5_q", 32'(bus.q), 0);
    // 6: asynchronous reset mid-WAIT, then the pending mismatch is re-served
    bus.x = 4'b0010;
    push(0, 1, 4'b0, -1);
    wait_ev(0, n);
    tick(1);
    reset = 1'b1;
    #1;
    chk_reset("rst6");
    push(0, 1, 4'b0, -1);
    push(1, 1, 4'b0010, 2);
    tick(2);
    reset = 1'b0;
    wait_ev(0, n);
    pulse_rdy(1);
    tick(4);
    chk("t6_q", 32'(bus.q), 32'h2);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
